oldland_dbus_arbiter: RTL

Two-master arbiter sharing the single Oldland memory bus between the data port of the memory stage (`d_*`) and the instruction-fetch port (`i_*`). It grants one master at a time, forwards the granted master's request to the bus, and steers `bus_ack`/`bus_error` back to that master only. Grants are round-robin. An optional watchdog terminates transactions that are never acknowledged.

---
 rtl/oldland_dbus_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/oldland_dbus_arbiter.sv
// Round-robin arbiter sharing the Oldland memory bus between the data port and instruction fetch.
// Optional grant watchdog enabled by defining OLDLAND_ARB_TIMEOUT_EN.
module oldland_dbus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_access,
    input  logic [29:0] d_addr,
    input  logic [3:0]  d_bytesel,
    input  logic        d_wr_en,
    input  logic [31:0] d_wr_val,
    output logic [31:0] d_data,
    output logic        d_ack,
    output logic        d_error,
    input  logic        i_access,
    input  logic [29:0] i_addr,
    output logic [31:0] i_data,
    output logic        i_ack,
    output logic        i_error,
    output logic        bus_access,
    output logic [29:0] bus_addr,
    output logic [3:0]  bus_bytesel,
    output logic        bus_wr_en,
    output logic [31:0] bus_wr_val,
    input  logic [31:0] bus_data,
    input  logic        bus_ack,
    input  logic        bus_error,
    output logic        d_grant,
    output logic        i_grant
);
    // Handshake: a master holds access and its request stable until ack or error;
    // the ack cycle ends the transaction and access seen afterwards is a new request.

    typedef enum logic [1:0] {IDLE, GNT_D, GNT_I} state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t state;
    logic   last_i;
    logic   timed_out;
    logic   forced_err;
    logic   done;

`ifdef OLDLAND_ARB_TIMEOUT_EN
    logic [7:0] count;

    // Clearing while idle guarantees a fresh count on every grant entry.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE)
            count <= 8'd0;
        else if (!(bus_ack || bus_error))
            count <= count + 8'd1;
    end

    assign timed_out = (state != IDLE) && (count == TIMEOUT_LIMIT);
`else
    logic unused_timeout_limit;

    assign unused_timeout_limit = ^TIMEOUT_LIMIT;
    assign timed_out = 1'b0;
`endif

    // A genuine ack in the watchdog cycle wins over the forced error.
    assign forced_err = timed_out && !bus_ack;
    assign done       = bus_ack || bus_error || timed_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last_i  <= 1'b1;
            d_grant <= 1'b0;
            i_grant <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_access && (!i_access || last_i)) begin
                        state   <= GNT_D;
                        d_grant <= 1'b1;
                    end else if (i_access) begin
                        state   <= GNT_I;
                        i_grant <= 1'b1;
                    end
                end
                GNT_D: begin
                    if (done || !d_access) begin
                        state   <= IDLE;
                        d_grant <= 1'b0;
                        last_i  <= 1'b0;
                    end
                end
                GNT_I: begin
                    if (done || !i_access) begin
                        state   <= IDLE;
                        i_grant <= 1'b0;
                        last_i  <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    d_grant <= 1'b0;
                    i_grant <= 1'b0;
                end
            endcase
        end
    end

    assign d_data = bus_data;
    assign i_data = bus_data;

    always_comb begin
        bus_access  = 1'b0;
        bus_addr    = 30'd0;
        bus_bytesel = 4'd0;
        bus_wr_en   = 1'b0;
        bus_wr_val  = 32'd0;
        d_ack       = 1'b0;
        d_error     = 1'b0;
        i_ack       = 1'b0;
        i_error     = 1'b0;
        case (state)
            GNT_D: begin
                bus_access  = d_access && !timed_out;
                bus_addr    = d_addr;
                bus_bytesel = d_bytesel;
                bus_wr_en   = d_wr_en;
                bus_wr_val  = d_wr_val;
                d_ack       = bus_ack;
                d_error     = bus_error || forced_err;
            end
            GNT_I: begin
                bus_access  = i_access && !timed_out;
                bus_addr    = i_addr;
                bus_bytesel = 4'b1111;
                i_ack       = bus_ack;
                i_error     = bus_error || forced_err;
            end
            default: ;
        endcase
    end

endmodule
